// File: rtl/imm_extend_stage_if.sv
// imm_extend_stage_if: valid/ready handshake bundle for the immediate-extension stage
interface imm_extend_stage_if #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_imm;
   logic [1:0]       in_mode;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;
   logic             out_ovf;
   modport master (
      output in_valid, in_imm, in_mode, out_ready,
      input  in_ready, out_valid, out_data, out_ovf
   );
   modport slave (
      input  in_valid, in_imm, in_mode, out_ready,
      output in_ready, out_valid, out_data, out_ovf
   );
endinterface

// File: rtl/imm_extend_stage.sv
// imm_extend_stage: registered immediate sign/zero/shift/upper extension with a skid buffer
module imm_extend_stage #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int SHIFT = 2
) (
   input logic clk,
   input logic rst_n,
   input logic flush,
   imm_extend_stage_if.slave bus
);
   logic [OUT_W-1:0] sext, shl, res, main_data, skid_data;
   logic             ovf, main_valid, main_ovf, skid_valid, skid_ovf, accept, pop;
   always_comb begin
      sext = OUT_W'($signed(bus.in_imm));
      shl  = sext << SHIFT;
      ovf  = 1'b0;
      // any bit shifted out must equal the surviving sign bit
      for (int i = OUT_W - SHIFT; i < OUT_W; i++) ovf = ovf | (sext[i] ^ shl[OUT_W-1]);
      res = bus.in_mode[1] ? (bus.in_mode[0] ? OUT_W'(bus.in_imm) << (OUT_W - IN_W) : shl)
                           : (bus.in_mode[0] ? OUT_W'(bus.in_imm) : sext);
      ovf = ovf & (bus.in_mode == 2'b10);
   end
   assign bus.in_ready  = !skid_valid;
   assign bus.out_valid = main_valid;
   assign bus.out_data  = main_data;
   assign bus.out_ovf   = main_ovf;
   assign accept        = bus.in_valid && !skid_valid;
   assign pop           = main_valid && bus.out_ready;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid <= 1'b0;
         main_data  <= '0;
         main_ovf   <= 1'b0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
         skid_ovf   <= 1'b0;
      end else if (flush) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (skid_valid && pop) begin
         main_data  <= skid_data;
         main_ovf   <= skid_ovf;
         skid_valid <= 1'b0;
      end else if (accept && (!main_valid || pop)) begin
         main_valid <= 1'b1;
         main_data  <= res;
         main_ovf   <= ovf;
      end else if (accept) begin
         skid_valid <= 1'b1;
         skid_data  <= res;
         skid_ovf   <= ovf;
      end else if (pop) begin
         main_valid <= 1'b0;
      end
   end
endmodule
